// File: rtl/fib_req_arbiter.sv
// fib_req_arbiter
//   Shares a single Fibonacci core among four requesters. An IDLE-state
//   round-robin arbiter picks one requester, its index is sent to the core,
//   and the result (or a timeout error) comes back tagged with the requester
//   number. Only one job is outstanding at a time.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   req_i, idx_i        per-requester request level and packed index slots
//   ack_o               one-hot grant pulse, combinational in the IDLE cycle
//   rsp_valid_o         one-cycle response strobe
//   rsp_id_o/f_o/err_o  response owner, result and timeout flag (held)
//   busy_o              high whenever a job is in progress
//   core_start_o        one-cycle start pulse to the Fibonacci core
//   core_i_o            latched index presented to the core
//   core_ready_i        core idle/ready
//   core_done_tick_i    core completion pulse, core_f_i valid with it
//
// The arbiter is written for exactly four requesters (2-bit IDs).

module fib_req_arbiter #(
    parameter int N_REQ  = 4,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 20
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*IDX_W-1:0] idx_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic                   rsp_valid_o,
    output logic [1:0]             rsp_id_o,
    output logic [DATA_W-1:0]      rsp_f_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic                   core_start_o,
    output logic [IDX_W-1:0]       core_i_o,
    input  logic                   core_ready_i,
    input  logic                   core_done_tick_i,
    input  logic [DATA_W-1:0]      core_f_i
);

    // Last WAIT count before giving up on the core
    localparam logic [5:0] TIMEOUT_CNT = 6'd47;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         rr_ptr_q;
    logic [1:0]         grant_id;
    logic [1:0]         cand;
    logic               grant_valid;
    logic               take_grant;
    logic               timeout_hit;
    logic [5:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         id_q;
    logic [1:0]         rsp_id_q;
    logic [DATA_W-1:0]  f_q;
    logic               err_q;

    // Round-robin search: start at rr_ptr_q and ascend modulo 4; the first
    // asserted request wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = rr_ptr_q;
        cand        = rr_ptr_q;
        for (int off = 0; off < 4; off++) begin
            cand = rr_ptr_q + 2'(off);
            if (!grant_valid && req_i[cand]) begin
                grant_valid = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign take_grant  = (state_q == IDLE) && grant_valid && core_ready_i;
    assign timeout_hit = (cnt_q == TIMEOUT_CNT);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state strobes. A completion tick on the
    // timeout count still counts as a normal completion.
    always_comb begin
        state_d      = state_q;
        ack_o        = '0;
        core_start_o = 1'b0;
        rsp_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_grant) begin
                    ack_o[grant_id] = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                core_start_o = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (core_done_tick_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job datapath: latch the granted index/ID, run the timeout counter and
    // capture the result. The response ID is copied only when leaving WAIT so
    // that the response fields stay stable while the next job is granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= 2'd0;
            cnt_q    <= 6'd0;
            idx_q    <= '0;
            id_q     <= 2'd0;
            rsp_id_q <= 2'd0;
            f_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_grant) begin
                        idx_q    <= idx_i[grant_id*IDX_W +: IDX_W];
                        id_q     <= grant_id;
                        rr_ptr_q <= grant_id + 2'd1;
                    end
                end
                ISSUE: begin
                    cnt_q <= 6'd0;
                end
                WAIT: begin
                    if (core_done_tick_i) begin
                        f_q      <= core_f_i;
                        err_q    <= 1'b0;
                        rsp_id_q <= id_q;
                    end else if (timeout_hit) begin
                        f_q      <= '0;
                        err_q    <= 1'b1;
                        rsp_id_q <= id_q;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign core_i_o  = idx_q;
    assign rsp_id_o  = rsp_id_q;
    assign rsp_f_o   = f_q;
    assign rsp_err_o = err_q;

endmodule

// File: tb/tb_fib_req_arbiter.sv
// tb_fib_req_arbiter
//   Drives batches of held requests into fib_req_arbiter, emulates the shared
//   Fibonacci core with a per-job latency, and compares grants, core starts
//   and responses against an expected-value queue built from a round-robin
//   order model and a plain Fibonacci reference.

module tb_fib_req_arbiter;

    localparam int N_REQ  = 4;
    localparam int IDX_W  = 5;
    localparam int DATA_W = 20;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*IDX_W-1:0] idx_i;
    logic [N_REQ-1:0]       ack_o;
    logic                   rsp_valid_o;
    logic [1:0]             rsp_id_o;
    logic [DATA_W-1:0]      rsp_f_o;
    logic                   rsp_err_o;
    logic                   busy_o;
    logic                   core_start_o;
    logic [IDX_W-1:0]       core_i_o;
    logic                   core_ready_i;
    logic                   core_done_tick_i;
    logic [DATA_W-1:0]      core_f_i;

    logic core_busy;
    logic force_unready;

    typedef struct {
        int id;
        int f;
        int err;
    } rsp_t;

    rsp_t exp_rsp_q[$];
    int   exp_grant_q[$];
    int   exp_core_idx_q[$];
    int   lat_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int model_rr = 0;
    int stim_idx[4];
    int stim_lat[4];
    int mon_k;
    rsp_t mon_r;

    assign core_ready_i = ~core_busy & ~force_unready;

    always #5 clk_i = ~clk_i;

    fib_req_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .idx_i           (idx_i),
        .ack_o           (ack_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_id_o        (rsp_id_o),
        .rsp_f_o         (rsp_f_o),
        .rsp_err_o       (rsp_err_o),
        .busy_o          (busy_o),
        .core_start_o    (core_start_o),
        .core_i_o        (core_i_o),
        .core_ready_i    (core_ready_i),
        .core_done_tick_i(core_done_tick_i),
        .core_f_i        (core_f_i)
    );

    // Reference Fibonacci, truncated to the result width
    function automatic int fib_ref(input int n);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t;
        a = 64'd0;
        b = 64'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return int'({12'd0, a[19:0]});
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ack"},        int'(ack_o), 0);
        checkOutput({tag, "_rsp_valid"},  int'(rsp_valid_o), 0);
        checkOutput({tag, "_rsp_id"},     int'(rsp_id_o), 0);
        checkOutput({tag, "_rsp_f"},      int'(rsp_f_o), 0);
        checkOutput({tag, "_rsp_err"},    int'(rsp_err_o), 0);
        checkOutput({tag, "_busy"},       int'(busy_o), 0);
        checkOutput({tag, "_core_start"}, int'(core_start_o), 0);
        checkOutput({tag, "_core_i"},     int'(core_i_o), 0);
    endtask

    task automatic flushQueues();
        exp_rsp_q.delete();
        exp_grant_q.delete();
        exp_core_idx_q.delete();
        lat_q.delete();
    endtask

    // Hold each request until its ack has been seen, then drop it
    task automatic driveUntilAcked();
        logic [3:0] a;
        int guard;
        guard = 0;
        while (req_i != 4'd0 && guard < 3000) begin
            @(negedge clk_i);
            a = ack_o;
            @(posedge clk_i);
            #1;
            req_i = req_i & ~a;
            guard++;
        end
        if (req_i != 4'd0) begin
            checkOutput("grant_timeout", int'(req_i), 0);
            req_i = 4'd0;
        end
    endtask

    // Predict the grant order for a batch of simultaneous held requests,
    // queue the expected traffic, then drive the batch and let it drain.
    task automatic applyStimulus(input logic [3:0] mask, input int hold);
        logic [3:0] left;
        int rr;
        int pos;
        int guard;
        left = mask;
        rr   = model_rr;
        pos  = 0;
        while (left != 4'd0) begin
            for (int o = 0; o < 4; o++) begin
                int k;
                k = (rr + o) % 4;
                if (left[k]) begin
                    rsp_t r;
                    r.id  = k;
                    r.err = (stim_lat[pos] >= 49) ? 1 : 0;
                    r.f   = r.err ? 0 : fib_ref(stim_idx[k]);
                    exp_grant_q.push_back(k);
                    exp_core_idx_q.push_back(stim_idx[k]);
                    lat_q.push_back(stim_lat[pos]);
                    exp_rsp_q.push_back(r);
                    left[k] = 1'b0;
                    rr = (k + 1) % 4;
                    break;
                end
            end
            pos++;
        end
        model_rr = rr;

        for (int k = 0; k < 4; k++) begin
            idx_i[k*IDX_W +: IDX_W] = IDX_W'(stim_idx[k]);
        end
        req_i = mask;

        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk_i);
                checkOutput("noready_ack", int'(ack_o), 0);
                checkOutput("noready_busy", int'(busy_o), 0);
            end
            @(posedge clk_i);
            #1;
            force_unready = 1'b0;
        end

        driveUntilAcked();

        guard = 0;
        while (exp_rsp_q.size() != 0 && guard < 3000) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (exp_rsp_q.size() != 0) begin
            checkOutput("rsp_timeout", exp_rsp_q.size(), 0);
            flushQueues();
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic runSingle(input int k, input int idx, input int lat);
        stim_idx[k] = idx;
        stim_lat[0] = lat;
        applyStimulus(4'b0001 << k, 0);
    endtask

    // Core emulation: a start seen at the beginning of a cycle produces a
    // done tick exactly lat cycles later; ready stays low meanwhile.
    initial begin
        int lat;
        int ci;
        core_busy        = 1'b0;
        core_done_tick_i = 1'b0;
        core_f_i         = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (core_start_o && !core_busy) begin
                lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
                ci  = int'(core_i_o);
                core_busy = 1'b1;
                repeat (lat) begin
                    @(posedge clk_i);
                    #1;
                end
                core_done_tick_i = 1'b1;
                core_f_i         = DATA_W'(fib_ref(ci));
                @(posedge clk_i);
                #1;
                core_done_tick_i = 1'b0;
                core_f_i         = '0;
                core_busy        = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every grant, core start and response the DUT
    // presents is matched against the next expected entry.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (ack_o != 4'd0) begin
                if (exp_grant_q.size() == 0) begin
                    checkOutput("ack_unexpected", int'(ack_o), 0);
                end else begin
                    mon_k = exp_grant_q.pop_front();
                    checkOutput("ack_grant", int'(ack_o), 1 << mon_k);
                end
            end
            if (core_start_o) begin
                if (exp_core_idx_q.size() == 0) begin
                    checkOutput("core_start_unexpected", int'(core_start_o), 0);
                end else begin
                    mon_k = exp_core_idx_q.pop_front();
                    checkOutput("core_idx", int'(core_i_o), mon_k);
                end
            end
            if (rsp_valid_o) begin
                if (exp_rsp_q.size() == 0) begin
                    checkOutput("rsp_unexpected", int'(rsp_valid_o), 0);
                end else begin
                    mon_r = exp_rsp_q.pop_front();
                    checkOutput("rsp_id", int'(rsp_id_o), mon_r.id);
                    checkOutput("rsp_f", int'(rsp_f_o), mon_r.f);
                    checkOutput("rsp_err", int'(rsp_err_o), mon_r.err);
                end
            end
        end
    end

    initial begin
        int r;
        logic [3:0] m;
        rst_i         = 1'b1;
        req_i         = '0;
        idx_i         = '0;
        force_unready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stim_idx[k] = 0;
            stim_lat[k] = 1;
        end

        repeat (3) @(posedge clk_i);
        #1;
        checkIdleOutputs("in_reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkIdleOutputs("after_reset");

        // All four requesting while the core is not ready, then released
        stim_idx = '{10, 0, 1, 31};
        stim_lat = '{3, 5, 1, 7};
        force_unready = 1'b1;
        applyStimulus(4'b1111, 5);

        // Single requests including edge indices
        runSingle(0, 10, 4);
        runSingle(1, 30, 2);
        runSingle(3, 31, 6);
        runSingle(2, 0, 1);
        runSingle(1, 1, 9);

        // Rotation: grant 2, then 0 and 2 together must favour 0
        runSingle(2, 5, 3);
        stim_idx[0] = 7;
        stim_idx[2] = 12;
        stim_lat = '{2, 2, 2, 2};
        applyStimulus(4'b0101, 0);

        // Stalled core, completion on the last count, one cycle too late
        runSingle(1, 20, 60);
        runSingle(3, 15, 48);
        runSingle(0, 25, 49);

        // Random batches
        for (int b = 0; b < 25; b++) begin
            m = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                stim_idx[k] = int'($urandom_range(0, 31));
                r = int'($urandom_range(0, 9));
                stim_lat[k] = (r == 0) ? 48 : (r == 1) ? 49 : int'($urandom_range(1, 12));
            end
            applyStimulus(m, 0);
        end

        // Reset while a job is waiting on the core
        exp_grant_q.push_back(2);
        exp_core_idx_q.push_back(9);
        lat_q.push_back(30);
        idx_i[2*IDX_W +: IDX_W] = 5'd9;
        req_i = 4'b0100;
        driveUntilAcked();
        repeat (6) @(posedge clk_i);
        #1;
        checkOutput("busy_in_wait", int'(busy_o), 1);
        rst_i = 1'b1;
        #1;
        checkIdleOutputs("mid_reset");
        flushQueues();
        model_rr = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (45) @(posedge clk_i);
        #1;
        checkIdleOutputs("post_reset_idle");

        // Pointer back at 0: requester 1 before 3
        stim_idx[1] = 11;
        stim_idx[3] = 13;
        stim_lat = '{4, 4, 4, 4};
        applyStimulus(4'b1010, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
